// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable FIFO: width helpers and read-mode constants.
`ifndef FIFO_PKG_SV
`define FIFO_PKG_SV

// Occupancy counter width: one bit wider than the pointers so DEPTH itself is representable.
`define FIFO_CNT_W(addr_w) ((addr_w) + 1)

package fifo_pkg;

  // Read-mode selectors for the FWFT parameter.
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Ceiling log2, usable in constant expressions (parameters, port widths).
  function automatic int fifo_clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

`endif

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [fifo_clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic [fifo_clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]             rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming word at the write address.
  // NOTE: storage is deliberately left out of reset; occupancy is tracked by the
  // control logic, so stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_prog.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and selectable FWFT read mode.
module fifo_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = FIFO_MODE_STD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       write,
  input  logic                       read,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           data_out,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       fifo_not_full,
  output logic                       fifo_not_empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [fifo_clog2(DEPTH):0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int ADDR_W = fifo_clog2(DEPTH);
  localparam int CNT_W  = `FIFO_CNT_W(ADDR_W);

  // Reject illegal configurations at elaboration time.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_prog: DEPTH (%0d) must be a power of two and at least 2", DEPTH);
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("fifo_prog: AF_LEVEL (%0d) must lie in 1..DEPTH", AF_LEVEL);
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $error("fifo_prog: AE_LEVEL (%0d) must lie in 0..DEPTH-1", AE_LEVEL);
  end

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_acc;
  logic              wr_acc;
  logic [WIDTH-1:0]  rd_data;

  // Status decodes of the registered occupancy; they move one cycle after the accepting edge.
  assign fifo_empty     = (count == '0);
  assign fifo_full      = (count == CNT_W'(DEPTH));
  assign fifo_not_empty = ~fifo_empty;
  assign fifo_not_full  = ~fifo_full;
  assign almost_full    = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty   = (count <= CNT_W'(AE_LEVEL));

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
  assign rd_acc = read & fifo_not_empty;
  assign wr_acc = write & (fifo_not_full | rd_acc);

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Advance pointers and occupancy on accepted transfers; pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (write & ~wr_acc) | (overflow & ~clr_err);
      underflow <= (read & ~rd_acc) | (underflow & ~clr_err);
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Head word is presented combinationally; zero while empty.
    assign data_out = fifo_not_empty ? rd_data : '0;
  end else begin : g_std
    logic [WIDTH-1:0] data_q;

    // Registered read: load the head word on an accepted read, otherwise hold.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q <= '0;
      end else if (rd_acc) begin
        data_q <= rd_data;
      end
    end

    assign data_out = data_q;
  end

endmodule

// File: tb/tb_fifo_prog.sv
// Self-checking bench for fifo_prog: a registered-read and an FWFT instance share stimulus
// and are compared by a monitor against a queue-based reference model.
module tb_fifo_prog;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             write;
  logic             read;
  logic             clr_err;

  logic [WIDTH-1:0] s_dout, f_dout;
  logic             s_full, s_empty, s_nfull, s_nempty, s_af, s_ae, s_ovf, s_udf;
  logic             f_full, f_empty, f_nfull, f_nempty, f_af, f_ae, f_ovf, f_udf;
  logic [2:0]       s_cnt, f_cnt;

  fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .data_in(data_in), .write(write), .read(read), .clr_err(clr_err),
    .data_out(s_dout), .fifo_full(s_full), .fifo_empty(s_empty), .fifo_not_full(s_nfull),
    .fifo_not_empty(s_nempty), .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
    .overflow(s_ovf), .underflow(s_udf)
  );

  fifo_prog #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .data_in(data_in), .write(write), .read(read), .clr_err(clr_err),
    .data_out(f_dout), .fifo_full(f_full), .fifo_empty(f_empty), .fifo_not_full(f_nfull),
    .fifo_not_empty(f_nempty), .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected post-edge state for one clock cycle.
  typedef struct {
    int               cnt;
    bit               ovf;
    bit               udf;
    logic [WIDTH-1:0] std_dout;
    logic [WIDTH-1:0] fwft_dout;
  } exp_t;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] data_q[$];

  // Reference model: the FIFO contents as a plain queue.
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf;
  bit               m_udf;
  logic [WIDTH-1:0] m_std_dout;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and record what the FIFO must look like after the edge.
  task automatic cycle(input bit w, input bit r, input bit clr, input logic [WIDTH-1:0] din);
    bit   rd_ok;
    bit   wr_ok;
    exp_t e;
    @(negedge clk);
    write   = w;
    read    = r;
    clr_err = clr;
    data_in = din;
    rd_ok = r && (mq.size() > 0);
    wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
    if (rd_ok) begin
      m_std_dout = mq.pop_front();
      data_q.push_back(m_std_dout);
    end
    if (wr_ok) mq.push_back(din);
    m_ovf = (w && !wr_ok) || (m_ovf && !clr);
    m_udf = (r && !rd_ok) || (m_udf && !clr);
    e.cnt       = mq.size();
    e.ovf       = m_ovf;
    e.udf       = m_udf;
    e.std_dout  = m_std_dout;
    e.fwft_dout = (mq.size() > 0) ? mq[0] : '0;
    exp_q.push_back(e);
  endtask

  // Monitor: compare both instances after every edge; pop read data when the DUT shows a read.
  initial begin
    bit   fire;
    exp_t e;
    forever begin
      @(posedge clk);
      fire = read && s_nempty;
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("std_count",     32'(s_cnt),    32'(e.cnt));
        check("std_full",      32'(s_full),   32'(e.cnt == DEPTH));
        check("std_empty",     32'(s_empty),  32'(e.cnt == 0));
        check("std_not_full",  32'(s_nfull),  32'(e.cnt != DEPTH));
        check("std_not_empty", 32'(s_nempty), 32'(e.cnt != 0));
        check("std_almost_full",  32'(s_af),  32'(e.cnt >= AF));
        check("std_almost_empty", 32'(s_ae),  32'(e.cnt <= AE));
        check("std_overflow",  32'(s_ovf),    32'(e.ovf));
        check("std_underflow", 32'(s_udf),    32'(e.udf));
        check("std_data_hold", 32'(s_dout),   32'(e.std_dout));
        check("fwft_count",    32'(f_cnt),    32'(e.cnt));
        check("fwft_overflow", 32'(f_ovf),    32'(e.ovf));
        check("fwft_underflow",32'(f_udf),    32'(e.udf));
        check("fwft_data_out", 32'(f_dout),   32'(e.fwft_dout));
      end
      if (fire) begin
        if (data_q.size() == 0) begin
          check("std_unexpected_read", 32'(s_dout), 32'hDEAD_BEEF);
        end else begin
          check("std_read_data", 32'(s_dout), 32'(data_q.pop_front()));
        end
      end
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    clr_err    = 1'b0;
    data_in    = '0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
    m_std_dout = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_count",     32'(s_cnt),    32'd0);
    check("rst_empty",     32'(s_empty),  32'd1);
    check("rst_not_empty", 32'(s_nempty), 32'd0);
    check("rst_full",      32'(s_full),   32'd0);
    check("rst_not_full",  32'(s_nfull),  32'd1);
    check("rst_almost_empty", 32'(s_ae),  32'd1);
    check("rst_almost_full",  32'(s_af),  32'd0);
    check("rst_overflow",  32'(s_ovf),    32'd0);
    check("rst_underflow", 32'(s_udf),    32'd0);
    check("rst_std_dout",  32'(s_dout),   32'd0);
    check("rst_fwft_dout", 32'(f_dout),   32'd0);
    rst = 1'b1;

    // Fill with 3,10,15,18 then read six times: two reads underflow, data holds 18.
    cycle(1, 0, 0, 16'd3);
    cycle(1, 0, 0, 16'd10);
    cycle(1, 0, 0, 16'd15);
    cycle(1, 0, 0, 16'd18);
    repeat (6) cycle(0, 1, 0, '0);
    cycle(0, 0, 1, '0);

    // Overflow on a full FIFO; 99 must never be read; clr_err clears the flag.
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 16'(20 + i));
    cycle(1, 0, 0, 16'd99);
    cycle(0, 0, 1, '0);

    // Full FIFO with simultaneous write 7 and read; 7 comes out last.
    cycle(1, 1, 0, 16'd7);
    repeat (4) cycle(0, 1, 0, '0);
    cycle(0, 0, 0, '0);

    // Threshold walk: count 1,2,3 then back to 1, then drain.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 16'(40 + i));
    repeat (3) cycle(0, 1, 0, '0);

    // Write 42 into empty FIFO; FWFT shows it without a read, one read empties it.
    cycle(1, 0, 0, 16'd42);
    cycle(0, 0, 0, '0);
    cycle(0, 1, 0, '0);
    cycle(0, 0, 0, '0);

    // Empty with simultaneous write and read: write taken, read rejected.
    cycle(1, 1, 0, 16'd55);
    cycle(0, 1, 1, '0);
    cycle(0, 0, 1, '0);

    // Asynchronous reset between edges discards data immediately.
    cycle(1, 0, 0, 16'd5);
    cycle(1, 0, 0, 16'd6);
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_count",     32'(s_cnt),   32'd0);
    check("arst_empty",     32'(s_empty), 32'd1);
    check("arst_std_dout",  32'(s_dout),  32'd0);
    check("arst_fwft_dout", 32'(f_dout),  32'd0);
    mq.delete();
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
    m_std_dout = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    cycle(1, 0, 0, 16'd8);
    cycle(0, 1, 0, '0);
    cycle(0, 0, 0, '0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), 16'($urandom));
    end
    cycle(0, 0, 1, '0);
    cycle(0, 0, 0, '0);
    @(negedge clk);

    check("scoreboard_state_drained", 32'(exp_q.size()),  32'd0);
    check("scoreboard_data_drained",  32'(data_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
